sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for buffering byte- or word-streams between producer and consumer blocks in the same clock domain. Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and synchronous flush. A compile-time first-word-fall-through read mode is also provided. Same full/empty handshake as the dual-clock FIFO: write while `~full`, read while `~empty`.

---
 rtl/sync_fifo_pkg.sv | 26 ++
 rtl/sync_fifo_ram.sv | 32 +++
 rtl/sync_fifo.sv | 161 ++++++++++++++++
 tb/tb_sync_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo slice: boolean constants, the
// occupancy-counter width helper and parameter legality checks used at
// elaboration time by sync_fifo.
package fifo_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit af_thresh_ok(input int thresh, input int depth);
        return (thresh >= 1) && (thresh <= depth);
    endfunction

    function automatic bit ae_thresh_ok(input int thresh, input int depth);
        return (thresh >= 0) && (thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage for sync_fifo: one synchronous write port and one
// asynchronous read port. The parent decides whether the read data is
// registered (standard mode) or used directly (first-word-fall-through).
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Asynchronous read port.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and synchronous flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise
// dout is registered and valid the cycle after an accepted read.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo: WIDTH must be at least 1");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end
    if (!af_thresh_ok(AF_THRESH, DEPTH)) begin : g_bad_af
        $error("sync_fifo: AF_THRESH must lie in 1..DEPTH");
    end
    if (!ae_thresh_ok(AE_THRESH, DEPTH)) begin : g_bad_ae
        $error("sync_fifo: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] rd_data;

    // Status flags decode from the registered occupancy only, so neither
    // acceptance path sees the opposite request combinationally.
    always_comb begin
        full         = (count_q == CW'(DEPTH));
        empty        = (count_q == '0);
        almost_full  = (count_q >= CW'(AF_THRESH));
        almost_empty = (count_q <= CW'(AE_THRESH));
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    // Request acceptance; flush overrides both requests.
    always_comb begin
        wr_acc = wr_en && !full && !clr;
        rd_acc = rd_en && !empty && !clr;
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = FALSE;
            underflow_d = FALSE;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_en && full) begin
                overflow_d = TRUE;
            end
            if (rd_en && empty) begin
                underflow_d = TRUE;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= FALSE;
            underflow_q <= FALSE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word falls through; meaningless while empty.
    always_comb begin
        dout = rd_data;
    end
`else
    logic [WIDTH-1:0] dout_q, dout_d;

    // Capture the head word only on an accepted read; hold otherwise.
    always_comb begin
        dout_d = rd_acc ? rd_data : dout_q;
    end

    // Registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    always_comb begin
        dout = dout_q;
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (WIDTH=8, DEPTH=16, AF=12, AE=2).
// Table-driven fill/drain plus hand sequences; read data is checked
// against a queue scoreboard. Works in both read modes.
module tb_sync_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             full, almost_full, empty, almost_empty;
    logic [4:0]       count;
    logic             overflow, underflow;

    sync_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .din          (din),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .dout         (dout),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] sb[$];

    typedef struct {
        logic       c, w, r;
        logic [7:0] d;
        int         cnt;
        logic       f, e, afl, ael, o, u;
    } vec_t;

    vec_t vt[33];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_flags(input string name, input int cnt, input logic f, input logic e,
                               input logic afl, input logic ael, input logic o, input logic u);
        check({name, ".count"},        32'(count),        cnt);
        check({name, ".full"},         32'(full),         32'(f));
        check({name, ".empty"},        32'(empty),        32'(e));
        check({name, ".almost_full"},  32'(almost_full),  32'(afl));
        check({name, ".almost_empty"}, 32'(almost_empty), 32'(ael));
        check({name, ".overflow"},     32'(overflow),     32'(o));
        check({name, ".underflow"},    32'(underflow),    32'(u));
    endtask

    // One clock: drive, advance, update scoreboard, compare read data.
    task automatic cycle(input logic c, input logic w, input logic r, input logic [7:0] d);
        logic       wacc, racc;
        logic [7:0] exp;
        exp  = '0;
        wacc = w && !c && (sb.size() < DEPTH);
        racc = r && !c && (sb.size() > 0);
`ifdef SYNC_FIFO_FWFT_EN
        if (racc) check("fwft_head", 32'(dout), 32'(sb[0]));
`endif
        clr   = c;
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
        if (c) begin
            sb.delete();
        end else begin
            if (racc) exp = sb.pop_front();
            if (wacc) sb.push_back(d);
        end
`ifndef SYNC_FIFO_FWFT_EN
        if (racc) check("rd_data", 32'(dout), 32'(exp));
`endif
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fill 0x01..0x10, one rejected write, then drain 16.
        for (int i = 0; i < 16; i++) begin
            vt[i] = '{1'b0, 1'b1, 1'b0, 8'(i + 1), i + 1, (i + 1 == 16), 1'b0,
                      (i + 1 >= AF), (i + 1 <= AE), 1'b0, 1'b0};
        end
        vt[16] = '{1'b0, 1'b1, 1'b0, 8'hEE, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 16; i++) begin
            vt[17 + i] = '{1'b0, 1'b0, 1'b1, 8'h00, 15 - i, 1'b0, (15 - i == 0),
                           (15 - i >= AF), (15 - i <= AE), 1'b1, 1'b0};
        end

        rst_n = 1'b0;
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        #12;
        check_flags("reset", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
        check("reset.dout", 32'(dout), 32'h0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
            cycle(vt[i].c, vt[i].w, vt[i].r, vt[i].d);
            check_flags($sformatf("vec%0d", i), vt[i].cnt, vt[i].f, vt[i].e,
                        vt[i].afl, vt[i].ael, vt[i].o, vt[i].u);
        end

        // Empty boundary: write accepted, read rejected.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check_flags("clr", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'h77);
        check_flags("bnd_empty", 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Full boundary: read accepted, write rejected.
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
        check_flags("refill", 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 8'hEE);
        check_flags("bnd_full", 15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Flush at count 7 with overflow set; same-cycle write dropped.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
        check_flags("pre_flush", 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 8'h55);
        check_flags("flush", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
        check("flush.dout_kept", 32'(dout), 32'h87);
`endif

        // Latency of a single word.
        cycle(1'b0, 1'b1, 1'b0, 8'hA5);
        check("lat.empty", 32'(empty), 32'h0);
`ifdef SYNC_FIFO_FWFT_EN
        check("lat.fwft_dout", 32'(dout), 32'hA5);
`endif
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
        check("lat.std_dout", 32'(dout), 32'hA5);
`endif
        check("lat.empty_after", 32'(empty), 32'h1);

        // Streaming at count 5 for 100 cycles.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 8'($urandom));
            check("stream.count", 32'(count), 32'd5);
        end

        // Asynchronous reset between edges at count 9.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        check("pre_rst.count", 32'(count), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check_flags("async_rst", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
        check("async_rst.dout", 32'(dout), 32'h0);
`endif
        #1;
        rst_n = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("post_rst.count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
